// File: rtl/speed_sensor_frontend.sv
// Tone-wheel front-end: synchronizes and deglitches the wheel and reference pulse inputs,
// counts filtered rising edges per gate window and publishes saturated counts plus a stall flag.
module speed_sensor_frontend #(
    parameter int unsigned GATE_CYCLES     = 1000,
    parameter int unsigned FILTER_LEN      = 3,
    parameter int unsigned TIMEOUT_WINDOWS = 4,
    parameter int unsigned STALL_MIN_VS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wheel_pulse_in,
    input  logic       vehicle_pulse_in,
    output logic [7:0] wheel_speed,
    output logic [7:0] vehicle_speed,
    output logic       speed_valid,
    output logic       wheel_stall
);

    localparam int unsigned GateW = $clog2(GATE_CYCLES);
    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [3:0] FiltLen = 4'(FILTER_LEN);
    localparam logic [3:0] TimeoutW = 4'(TIMEOUT_WINDOWS);
    localparam logic [7:0] MinVs = 8'(STALL_MIN_VS);

    // Channel 0 is the wheel, channel 1 the vehicle reference.
    logic [1:0] raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt_q, filt_d;
    logic [1:0] rise;
    logic [3:0] stab_q [2];
    logic [3:0] stab_d [2];
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];
    logic [7:0] cnt_sat [2];

    logic [GateW-1:0] gate_q, gate_d;
    logic [3:0]       stall_cnt_q, stall_cnt_d;
    logic [7:0]       wheel_speed_q, wheel_speed_d;
    logic [7:0]       vehicle_speed_q, vehicle_speed_d;
    logic             valid_q, valid_d;
    logic             stall_q, stall_d;
    logic             term;

    assign raw  = {vehicle_pulse_in, wheel_pulse_in};
    assign term = enable && (gate_q == GateLast);

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            filt_d[c] = filt_q[c];
            stab_d[c] = '0;
            rise[c]   = 1'b0;
            if (sync2_q[c] != filt_q[c]) begin
                if (stab_q[c] + 4'd1 == FiltLen) begin
                    filt_d[c] = sync2_q[c];
                    rise[c]   = sync2_q[c];
                end else begin
                    stab_d[c] = stab_q[c] + 4'd1;
                end
            end
            // Includes this cycle's edge so a terminal-cycle edge lands in the closing window.
            cnt_sat[c] = (cnt_q[c] == 8'hFF) ? 8'hFF : cnt_q[c] + {7'd0, rise[c]};
        end
    end

    always_comb begin
        gate_d          = '0;
        cnt_d[0]        = '0;
        cnt_d[1]        = '0;
        stall_cnt_d     = '0;
        wheel_speed_d   = wheel_speed_q;
        vehicle_speed_d = vehicle_speed_q;
        valid_d         = 1'b0;
        stall_d         = stall_q;
        if (enable) begin
            if (term) begin
                wheel_speed_d   = cnt_sat[0];
                vehicle_speed_d = cnt_sat[1];
                valid_d         = 1'b1;
                if (cnt_sat[0] == 8'd0 && cnt_sat[1] > MinVs) begin
                    stall_cnt_d = (stall_cnt_q >= TimeoutW) ? TimeoutW : stall_cnt_q + 4'd1;
                end
                stall_d = (stall_cnt_d >= TimeoutW);
            end else begin
                gate_d      = gate_q + 1'b1;
                cnt_d[0]    = cnt_sat[0];
                cnt_d[1]    = cnt_sat[1];
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            filt_q          <= '0;
            stab_q[0]       <= '0;
            stab_q[1]       <= '0;
            cnt_q[0]        <= '0;
            cnt_q[1]        <= '0;
            gate_q          <= '0;
            stall_cnt_q     <= '0;
            wheel_speed_q   <= '0;
            vehicle_speed_q <= '0;
            valid_q         <= 1'b0;
            stall_q         <= 1'b0;
        end else begin
            sync1_q         <= raw;
            sync2_q         <= sync1_q;
            filt_q          <= filt_d;
            stab_q[0]       <= stab_d[0];
            stab_q[1]       <= stab_d[1];
            cnt_q[0]        <= cnt_d[0];
            cnt_q[1]        <= cnt_d[1];
            gate_q          <= gate_d;
            stall_cnt_q     <= stall_cnt_d;
            wheel_speed_q   <= wheel_speed_d;
            vehicle_speed_q <= vehicle_speed_d;
            valid_q         <= valid_d;
            stall_q         <= stall_d;
        end
    end

    assign wheel_speed   = wheel_speed_q;
    assign vehicle_speed = vehicle_speed_q;
    assign speed_valid   = valid_q;
    assign wheel_stall   = stall_q;

endmodule

// File: tb/tb_speed_sensor_frontend.sv
// Bench for speed_sensor_frontend: window-level reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_speed_sensor_frontend;

    localparam int G     = 100;
    localparam int F     = 3;
    localparam int T     = 4;
    localparam int MINVS = 5;
    localparam int GSAT  = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       wheel_pin;
    logic       vehicle_pin;
    logic [7:0] ws, vs, sat_ws, sat_vs;
    logic       sv, stall, sat_sv, sat_stall;

    int checks   = 0;
    int failures = 0;
    int w_per, w_hi, v_per, v_hi, phase;

    always #5 clk = ~clk;

    speed_sensor_frontend #(
        .GATE_CYCLES(G), .FILTER_LEN(F), .TIMEOUT_WINDOWS(T), .STALL_MIN_VS(MINVS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .wheel_pulse_in(wheel_pin), .vehicle_pulse_in(vehicle_pin),
        .wheel_speed(ws), .vehicle_speed(vs), .speed_valid(sv), .wheel_stall(stall)
    );

    speed_sensor_frontend #(
        .GATE_CYCLES(GSAT), .FILTER_LEN(F), .TIMEOUT_WINDOWS(T), .STALL_MIN_VS(MINVS)
    ) dut_sat (
        .clk(clk), .reset(reset), .enable(enable),
        .wheel_pulse_in(wheel_pin), .vehicle_pulse_in(vehicle_pin),
        .wheel_speed(sat_ws), .vehicle_speed(sat_vs), .speed_valid(sat_sv),
        .wheel_stall(sat_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input logic [31:0] act, input int lo, input int hi);
        checks++;
        if ((^act === 1'bx) || act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model: a level change is accepted once F consecutive synchronized samples disagree with
    // the filtered level; edges are tallied per window and published saturated.
    bit [1:0]   m_dly [2];
    bit         m_hist [2][F];
    int         m_fill [2];
    bit         m_filt [2];
    bit         m_rise [2];
    int         m_win [2];
    int         m_pos, m_zero;
    bit [1:0]   m_pin;
    bit         m_aged, m_all;
    logic [7:0] exp_ws, exp_vs;
    logic       exp_valid, exp_stall;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_dly[c]  = 2'b00;
                m_fill[c] = 0;
                m_filt[c] = 1'b0;
                m_win[c]  = 0;
            end
            m_pos = 0; m_zero = 0;
            exp_ws = 8'd0; exp_vs = 8'd0; exp_valid = 1'b0; exp_stall = 1'b0;
        end else begin
            m_pin = {vehicle_pin, wheel_pin};
            for (int c = 0; c < 2; c++) begin
                m_aged   = m_dly[c][1];
                m_dly[c] = {m_dly[c][0], m_pin[c]};
                for (int i = F - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
                m_hist[c][0] = m_aged;
                if (m_fill[c] < F) m_fill[c]++;
                m_all = (m_fill[c] >= F);
                for (int i = 0; i < F; i++) if (m_hist[c][i] == m_filt[c]) m_all = 1'b0;
                m_rise[c] = 1'b0;
                if (m_all) begin
                    m_filt[c] = ~m_filt[c];
                    m_rise[c] = m_filt[c];
                end
            end
            exp_valid = 1'b0;
            if (enable) begin
                for (int c = 0; c < 2; c++) if (m_rise[c]) m_win[c]++;
                if (m_pos == G - 1) begin
                    exp_ws    = 8'((m_win[0] > 255) ? 255 : m_win[0]);
                    exp_vs    = 8'((m_win[1] > 255) ? 255 : m_win[1]);
                    exp_valid = 1'b1;
                    if (m_win[0] == 0 && m_win[1] > MINVS) m_zero++;
                    else m_zero = 0;
                    exp_stall = (m_zero >= T);
                    m_win[0] = 0; m_win[1] = 0; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end else begin
                m_win[0] = 0; m_win[1] = 0; m_pos = 0; m_zero = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_wheel_speed", ws, exp_ws);
        chk("cmp_vehicle_speed", vs, exp_vs);
        chk("cmp_speed_valid", sv, exp_valid);
        chk("cmp_wheel_stall", stall, exp_stall);
    end

    task automatic tick();
        @(negedge clk);
        phase++;
        wheel_pin   = (w_per > 0) && ((phase % w_per) < w_hi);
        vehicle_pin = (v_per > 0) && ((phase % v_per) < v_hi);
    endtask

    task automatic wait_strobe(input bit use_sat, input int limit, input string name,
                               output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(use_sat ? sat_sv : sv) && n < limit);
        if (!(use_sat ? sat_sv : sv)) begin
            checks++;
            failures++;
            $display("FAIL %s: got no speed_valid expected one within %0d cycles", name, limit);
        end
    endtask

    int n, nstrobe;

    initial begin
        reset = 1'b1; enable = 1'b0; wheel_pin = 1'b0; vehicle_pin = 1'b0;
        w_per = 0; w_hi = 0; v_per = 0; v_hi = 0; phase = 0;
        repeat (3) tick();
        chk("reset_wheel_speed", ws, 0);
        chk("reset_vehicle_speed", vs, 0);
        chk("reset_speed_valid", sv, 0);
        chk("reset_wheel_stall", stall, 0);

        // Nominal rate
        w_per = 10; w_hi = 5; v_per = 8; v_hi = 4;
        reset = 1'b0; enable = 1'b1;
        wait_strobe(1'b0, 200, "first_strobe", n);
        chk("first_strobe_latency", n, 100);
        wait_strobe(1'b0, 200, "nominal_strobe", n);
        chk("strobe_period", n, 100);
        chk("nominal_wheel", ws, 10);
        chk_rng("nominal_vehicle", vs, 11, 13);
        chk("nominal_stall", stall, 0);
        tick();
        chk("valid_one_cycle", sv, 0);

        // Enable gating mid-window
        repeat (49) tick();
        enable = 1'b0;
        nstrobe = 0;
        repeat (150) begin
            tick();
            if (sv) nstrobe++;
        end
        chk("disabled_strobes", nstrobe, 0);
        chk("disabled_frozen_wheel", ws, 10);
        enable = 1'b1;
        wait_strobe(1'b0, 200, "reenable_strobe", n);
        chk("reenable_latency", n, 100);
        chk("reenable_wheel", ws, 10);

        // Glitch rejection: 2-cycle highs rejected, 3-cycle highs accepted
        w_hi = 2;
        repeat (2) wait_strobe(1'b0, 200, "glitch_strobe", n);
        chk("glitch2_wheel", ws, 0);
        w_hi = 3;
        repeat (2) wait_strobe(1'b0, 200, "pulse3_strobe", n);
        chk("pulse3_wheel", ws, 10);

        // Stall: wheel held low while vehicle moves
        #1 reset = 1'b1;
        w_per = 0; v_per = 8; v_hi = 4;
        tick(); tick();
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wait_strobe(1'b0, 200, "stall_strobe", n);
            chk($sformatf("stall_at_strobe%0d", k), stall, (k == 4) ? 1 : 0);
        end
        w_per = 10; w_hi = 5;
        wait_strobe(1'b0, 200, "stall_clear_strobe", n);
        chk("stall_cleared", stall, 0);
        w_per = 0; v_per = 20; v_hi = 10;
        for (int k = 1; k <= 6; k++) begin
            wait_strobe(1'b0, 200, "slow_vehicle_strobe", n);
            chk($sformatf("no_stall_slow_vehicle%0d", k), stall, 0);
        end
        chk("slow_vehicle_count", vs, 5);

        // Asynchronous reset mid-window
        w_per = 10; w_hi = 5; v_per = 8; v_hi = 4;
        repeat (2) wait_strobe(1'b0, 200, "pre_reset_strobe", n);
        chk("pre_reset_wheel", ws, 10);
        repeat (70) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_reset_wheel", ws, 0);
        chk("async_reset_vehicle", vs, 0);
        chk("async_reset_stall", stall, 0);
        tick(); tick();
        reset = 1'b0;
        wait_strobe(1'b0, 200, "post_reset_strobe", n);
        chk("post_reset_latency", n, 100);
        chk_rng("post_reset_wheel", ws, 9, 11);

        // Saturation on the long-gate instance
        w_per = 6; w_hi = 3;
        wait_strobe(1'b1, 2100, "sat_strobe1", n);
        wait_strobe(1'b1, 2100, "sat_strobe2", n);
        chk("sat_latency", n, 2000);
        chk("sat_wheel", sat_ws, 255);
        chk("sat_vehicle", sat_vs, 250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
